// File: rtl/dpa_pkg.sv
// dpa_pkg: shared constants and types for the DPA pixel scaler
package dpa_pkg;
  localparam int DPA_PIX_W = 24;
  localparam int FB_DIM = 256;
  localparam int FB_PIXELS = 65536;
  localparam logic [1:0] SZ_128 = 2'b01;
  localparam logic [1:0] SZ_512 = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REP, S_FIN} state_e;
endpackage

// File: rtl/dpa_avg_acc.sv
// dpa_avg_acc: three 10-bit channel accumulators producing the rounded 2x2 average
module dpa_avg_acc import dpa_pkg::*; (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 add_i,
  input  logic                 clr_i,
  input  logic [DPA_PIX_W-1:0] pix_i,
  output logic [DPA_PIX_W-1:0] avg_o
);
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [9:0] acc_q;
    logic [9:0] sum;
    // the result folds in the quad's 4th pixel so it is ready in the same cycle
    assign sum = acc_q + {2'b0, pix_i[8*c +: 8]} + 10'd2;
    assign avg_o[8*c +: 8] = sum[9:2];
    // running sum of the first three pixels of a quad; cleared as the 4th is consumed
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) acc_q <= '0;
      else if (clr_i) acc_q <= '0;
      else if (add_i) acc_q <= acc_q + {2'b0, pix_i[8*c +: 8]};
  end
endmodule

// File: rtl/dpa_scaler.sv
// dpa_scaler: scales a 128/256/512 square photo stream to 256x256 frame-buffer pixels
module dpa_scaler import dpa_pkg::*; #(
  parameter int PIX_W = DPA_PIX_W,
  parameter int FB_AW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       size,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic [FB_AW-1:0] out_addr,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  state_e state_q, state_d;
  logic [1:0] mode_q, quad_q;
  logic [FB_AW-1:0] out_cnt_q, ld_cnt_q, addr_q, nxt_addr;
  logic [PIX_W-1:0] pix_q, avg;
  logic valid_q, is128, is512, quad_last, in_hs, out_hs, load, rep_next, go;
  assign is128 = mode_q == SZ_128;
  assign is512 = mode_q == SZ_512;
  assign quad_last = quad_q == 2'd3;
  assign go = start && state_q == S_IDLE;
  assign out_hs = valid_q && out_ready;
  assign in_ready = state_q == S_RUN && (!valid_q || out_ready || (is512 && !quad_last));
  assign in_hs = in_valid && in_ready;
  assign load = in_hs && (!is512 || quad_last);
  assign rep_next = state_q == S_REP && out_hs && !(&out_cnt_q[1:0]);
  assign nxt_addr = is128 ? {ld_cnt_q[FB_AW-1:9], ld_cnt_q[1], ld_cnt_q[8:2], ld_cnt_q[0]} : ld_cnt_q;
  assign out_valid = valid_q;
  assign out_pix = pix_q;
  assign out_addr = addr_q;
  assign out_last = valid_q && out_cnt_q == FB_AW'(FB_PIXELS - 1);
  assign busy = state_q == S_RUN || state_q == S_REP;
  assign done = state_q == S_FIN;
  dpa_avg_acc u_acc (
    .clk   (clk),
    .rst_n (reset),
    .add_i (in_hs && is512 && !quad_last),
    .clr_i (go || (in_hs && is512 && quad_last)),
    .pix_i (in_pix),
    .avg_o (avg)
  );
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= S_IDLE;
    else state_q <= state_d;
  // next state: 128 mode detours through REP for each input pixel's four copies
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: if (is128 && in_hs) state_d = S_REP; else if (out_hs && out_last) state_d = S_FIN;
      S_REP: if (out_hs && &out_cnt_q[1:0]) state_d = out_last ? S_FIN : S_RUN;
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // mode latch, counters and the single-entry output register
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mode_q <= '0;
      quad_q <= '0;
      out_cnt_q <= '0;
      ld_cnt_q <= '0;
      addr_q <= '0;
      pix_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (go) begin
        mode_q <= size;
        quad_q <= '0;
        out_cnt_q <= '0;
        ld_cnt_q <= '0;
      end
      if (in_hs && is512) quad_q <= quad_q + 2'd1;
      if (out_hs) out_cnt_q <= out_cnt_q + 1'b1;
      if (load || rep_next) begin
        ld_cnt_q <= ld_cnt_q + 1'b1;
        addr_q <= nxt_addr;
        valid_q <= 1'b1;
      end else if (out_hs) valid_q <= 1'b0;
      if (load) pix_q <= is512 ? avg : in_pix;
    end
endmodule

// File: tb/tb_dpa_scaler.sv
// tb_dpa_scaler: directed-vector bench for the DPA pixel scaler
module tb_dpa_scaler;
  import dpa_pkg::*;
  logic clk = 0, reset = 0, start = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_last, busy, done;
  logic [1:0] size = 2'b00;
  logic [23:0] in_pix = 24'h0, out_pix;
  logic [15:0] out_addr;
  int n_chk = 0, n_fail = 0;
  logic [7:0] quad_tab [4][4];
  logic [23:0] quad_exp [4];
  logic [15:0] rep_addr [4];

  always #5 clk = ~clk;

  dpa_scaler dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .size      (size),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] gen(input logic [1:0] sz, input int i);
    int q, n;
    q = i >> 2;
    n = i & 3;
    if (sz == SZ_512) return q < 4 ? {3{quad_tab[q][n]}} : {8'(q + n), 8'(q * 3 + n * 7), 8'((q >> 2) ^ n)};
    if (sz == SZ_128) return i == 259 ? 24'h123456 : {8'(i), 8'(i >> 6), 8'hC3};
    return {8'(i), 8'(i >> 8), 8'h5A};
  endfunction

  function automatic logic [23:0] exp_pix(input logic [1:0] sz, input int k);
    logic [23:0] r, p;
    int s;
    if (sz == SZ_128) return gen(sz, k >> 2);
    if (sz != SZ_512) return gen(sz, k);
    if (k < 4) return quad_exp[k];
    r = 24'h0;
    for (int ch = 0; ch < 3; ch++) begin
      s = 2;
      for (int n = 0; n < 4; n++) begin
        p = gen(sz, 4 * k + n);
        s += int'(p >> (8 * ch)) & 255;
      end
      r |= 24'((s / 4) << (8 * ch));
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_addr(input logic [1:0] sz, input int k);
    int i;
    i = k / 4;
    if (sz != SZ_128) return 16'(k);
    return 16'(((i / 128) * 2 + (k / 2) % 2) * 256 + (i % 128) * 2 + k % 2);
  endfunction

  task automatic run(input logic [1:0] sz, input int n_out, input bit rnd, input int exp_cyc);
    int k, in_idx, cyc, n_in, limit;
    bit hs_in, hs_out, stalled;
    logic [39:0] prev;
    k = 0; in_idx = 0; cyc = 0; stalled = 0; prev = '0;
    n_in = sz == SZ_512 ? 262144 : sz == SZ_128 ? 16384 : 65536;
    limit = n_out * 12 + 100;
    start = 1; size = sz;
    @(posedge clk); #1;
    start = 0;
    size = sz ^ 2'b01;
    chk("busy_after_start", busy, 1);
    in_valid = 1;
    in_pix = gen(sz, 0);
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (k < n_out && cyc < limit) begin
      @(negedge clk);
      if (stalled) chk("stall_hold", {out_valid, out_addr, out_pix}, {1'b1, prev});
      hs_out = out_valid && out_ready;
      hs_in = in_valid && in_ready;
      if (hs_out) begin
        chk("out", {out_last, out_addr, out_pix}, {k == 65535, exp_addr(sz, k), exp_pix(sz, k)});
        if (sz == SZ_128 && k >= 1036 && k < 1040) begin
          chk("rep_in_ready", in_ready, 0);
          chk("rep_copy", {out_addr, out_pix}, {rep_addr[k - 1036], 24'h123456});
        end
        k++;
      end
      stalled = out_valid && !out_ready;
      prev = {out_addr, out_pix};
      @(posedge clk); #1;
      if (hs_in) in_idx++;
      in_valid = in_idx < n_in;
      in_pix = gen(sz, in_idx);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
      start = cyc == 10;
    end
    start = 0;
    chk("out_count", k, n_out);
    if (exp_cyc != 0) chk("cycles", cyc, exp_cyc);
  endtask

  task automatic do_reset();
    reset = 0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    in_valid = 0;
    start = 0;
    @(posedge clk); #1;
    reset = 1;
  endtask

  initial begin
    quad_tab = '{'{8'd1, 8'd2, 8'd2, 8'd2}, '{8'd255, 8'd255, 8'd255, 8'd255},
                 '{8'd0, 8'd0, 8'd0, 8'd1}, '{8'd0, 8'd0, 8'd1, 8'd1}};
    quad_exp = '{24'h020202, 24'hFFFFFF, 24'h000000, 24'h010101};
    rep_addr = '{16'h0406, 16'h0407, 16'h0506, 16'h0507};
    in_valid = 1;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_pix", out_pix, 0);
    chk("reset_out_addr", out_addr, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    in_valid = 0;
    run(2'b00, 65536, 0, 65537);
    chk("done_pulse", done, 1);
    chk("busy_fall", busy, 0);
    chk("fin_in_ready", in_ready, 0);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("start_in_fin_ignored", busy, 0);
    chk("done_one_cycle", done, 0);
    run(2'b10, 1000, 1, 0);
    do_reset();
    run(SZ_512, 16, 0, 65);
    do_reset();
    run(SZ_512, 1000, 1, 0);
    do_reset();
    run(SZ_128, 1100, 1, 0);
    do_reset();
    run(SZ_128, 16, 0, 20);
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dpa_scaler.md
# dpa_scaler

Pixel-stream scaler between the DPA image-memory read path and the frame-buffer write path. It accepts 24-bit RGB pixels of a 128×128, 256×256 or 512×512 photo and emits exactly 65536 frame-buffer pixels, each tagged with its 16-bit frame-buffer offset. 128×128 photos are upsampled by 2×2 replication. 512×512 photos are downsampled by a rounded 2×2 average. 256×256 photos pass through unchanged.

## Interface
- `PIX_W`, 24: pixel width, packed R[23:16] G[15:8] B[7:0].
- `FB_AW`, 16: frame-buffer offset width (256×256).
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; low clears all state immediately.
- `start`  in  1  one-cycle pulse; latches `size` and begins a photo. Ignored while `busy`.
- `size`  in  2  photo size: 01=128, 11=512, 00/10=256 (same encoding as `curr_photo_size`).
- `in_valid`  in  1  upstream pixel valid.
- `in_ready`  out  1  scaler accepts `in_pix`; transfer when `in_valid && in_ready`.
- `in_pix`  in  PIX_W  input pixel.
- `out_valid`  out  1  output pixel valid; held until accepted.
- `out_ready`  in  1  downstream accepts; transfer when `out_valid && out_ready`.
- `out_pix`  out  PIX_W  output pixel.
- `out_addr`  out  FB_AW  frame-buffer offset of `out_pix`, computed as row*256+col.
- `out_last`  out  1  high with the 65536th output pixel.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse in the cycle after the last output handshake.

## Operation
- Reset values: `in_ready`=0, `out_valid`=0, `out_pix`=0, `out_addr`=0, `out_last`=0, `busy`=0, `done`=0. State is IDLE and all counters are 0.
- States:
  - IDLE: `start` goes to RUN.
  - RUN: accepts input.
  - REP: 128 mode only; emits the four copies.
  - FIN: drives `done`, then returns to IDLE.
- Output register: single entry. Its contents are frozen while `out_valid && !out_ready`.
- 256 mode:
  - Input arrives in raster order.
  - Output is the input pixel, with `out_addr` running 0..65535.
  - `in_ready = RUN && (!out_valid || out_ready)`.
- 512 mode:
  - Input arrives in quad order per output pixel: (2x,2y), (2x+1,2y), (2x,2y+1), (2x+1,2y+1), with output pixels in raster order. 262144 inputs in total.
  - Per-channel 10-bit accumulator. Result per channel = (sum+2)>>2; the sum never overflows 10 bits.
  - On the 4th input of a quad, the output register is loaded and the accumulator is cleared in the same cycle.
  - `in_ready` for inputs 1–3 of a quad = RUN. For input 4 it is RUN && (!out_valid || out_ready).
- 128 mode:
  - Input arrives in raster order (x,y), 16384 inputs.
  - An accepted pixel moves the block to REP, which emits four copies at offsets a, a+1, a+256, a+257, in that order, where a = (2y)*256 + 2x.
  - `in_ready` = 0 in REP. When the 4th copy is accepted, the block returns to RUN, or goes to FIN if it was the last copy.
- The output counter increments per output handshake. `out_last` = (counter == 65535). The handshake of the last pixel moves the block to FIN.
- `size` is sampled only on `start`. Changes during `busy` have no effect.
- `in_valid` while IDLE/FIN is ignored, because `in_ready` = 0.

## Timing
- Latency: from the input handshake that completes an output pixel to `out_valid` is 1 cycle in all modes.
- Throughput with `out_ready` held high:
  - 256 mode: 1 output per cycle.
  - 512 mode: 1 output per 4 cycles.
  - 128 mode: 4 outputs per 5 cycles.
- `out_ready` low stalls the block without loss. Every input is reflected in exactly one output (256/512 modes) or four outputs (128 mode).
- `done` is asserted the cycle after the `out_last` handshake. `busy` falls in the same cycle `done` rises.
- `start` in the same cycle as `done` is ignored. `start` is accepted from IDLE on the next cycle.
- `reset` low mid-photo clears everything. After release, a new `start` is required.

## Structure
- Shared package `dpa_pkg` holds:
  - the size encodings SZ_128=2'b01, SZ_512=2'b11;
  - FB_DIM=256 and FB_PIXELS=65536;
  - the pixel width and the state enum.
- Sub-module `dpa_avg_acc`: the three 10-bit channel accumulators with clear/add/rounded-result, used only in 512 mode.
- Top level holds the FSM, the input/output counters, the address generator and the output register.

## Test plan
- 256 mode, ramp input pixel i = {8'(i),8'(i>>8),8'h5A}, `out_ready`=1 → 65536 outputs, `out_addr`==i, `out_pix` equal to input, `done` one cycle after `out_last`.
- 512 mode, quad R values 1,2,2,2 (sum 7) → R=2. Quad 255×4 → 255. Quad 0,0,0,1 → 0. Quad 0,0,1,1 → 1. Addresses are raster 0..65535.
- 128 mode, input (x=3,y=2) pixel 24'h123456 → four outputs at 0x0406, 0x0407, 0x0506, 0x0507, each 24'h123456. `in_ready` is low during the copies.
- Random `out_ready` (50% duty) in each mode → output stream is identical to the `out_ready`=1 run, and `out_pix`/`out_addr` are stable while stalled.
- `reset` low at output 1000 of a 512-mode run, then `start` with size 01 → clean 128-mode run from `out_addr` 0. `start` pulsed mid-run is ignored.
